// File: rtl/plru_way_allocator.sv
// Tree-PLRU victim allocator for one cache set: tracks hits and refills in a heap-ordered
// PLRU tree and grants unreserved, unlocked victim ways over a req/gnt handshake.
module plru_way_allocator #(
    parameter int unsigned WAYS     = 8,
    parameter int unsigned LOG_WAYS = $clog2(WAYS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                touch_valid_i,
    input  logic [LOG_WAYS-1:0] touch_way_i,
    input  logic [WAYS-1:0]     lock_i,
    input  logic                alloc_req_i,
    output logic                alloc_gnt_o,
    output logic [LOG_WAYS-1:0] alloc_way_o,
    output logic [WAYS-1:0]     alloc_way_oh_o,
    output logic                alloc_full_o,
    input  logic                fill_done_i,
    input  logic [LOG_WAYS-1:0] fill_way_i,
    output logic [WAYS-1:0]     reserved_o,
    output logic                illegal_fill_o
);

    typedef enum logic [1:0] {IDLE, SEL, GNT} state_t;

    state_t              state_q, state_d;
    logic [WAYS-2:0]     tree_q, tree_d;
    logic [WAYS-1:0]     reserved_q, reserved_d;
    logic [LOG_WAYS-1:0] way_q, way_d;
    logic [WAYS-1:0]     way_oh_q, way_oh_d;
    logic                illegal_q, illegal_d;
    logic [WAYS-1:0]     eligible;
    logic [LOG_WAYS-1:0] victim;

    // Walk root to leaf along w, pointing every visited node away from w.
    function automatic logic [WAYS-2:0] plru_update(input logic [WAYS-2:0] t,
                                                    input logic [LOG_WAYS-1:0] w);
        logic [WAYS-2:0]     r;
        logic [LOG_WAYS-1:0] node;
        logic [LOG_WAYS-1:0] ws;
        logic                b;
        r    = t;
        node = '0;
        ws   = w;
        for (int unsigned l = 0; l < LOG_WAYS; l++) begin
            b       = ws[LOG_WAYS-1];
            r[node] = ~b;
            node    = (node << 1) + LOG_WAYS'(1) + LOG_WAYS'(b);
            ws      = ws << 1;
        end
        return r;
    endfunction

    // A node bit is only followed when both halves still hold an eligible way.
    function automatic logic [LOG_WAYS-1:0] plru_victim(input logic [WAYS-2:0] t,
                                                        input logic [WAYS-1:0] elig);
        logic [WAYS-1:0]     sub;
        logic [LOG_WAYS-1:0] node;
        logic [LOG_WAYS-1:0] v;
        logic [LOG_WAYS-1:0] jsh;
        logic                lo_any, hi_any, go_hi;
        sub  = '1;
        node = '0;
        v    = '0;
        for (int unsigned l = 0; l < LOG_WAYS; l++) begin
            lo_any = 1'b0;
            hi_any = 1'b0;
            for (int unsigned j = 0; j < WAYS; j++) begin
                jsh = LOG_WAYS'(j) << l;
                if (sub[j] && elig[j]) begin
                    if (jsh[LOG_WAYS-1]) hi_any = 1'b1;
                    else                 lo_any = 1'b1;
                end
            end
            go_hi = !lo_any ? 1'b1 : (!hi_any ? 1'b0 : t[node]);
            for (int unsigned j = 0; j < WAYS; j++) begin
                jsh = LOG_WAYS'(j) << l;
                if (jsh[LOG_WAYS-1] != go_hi) sub[j] = 1'b0;
            end
            v    = (v << 1) | LOG_WAYS'(go_hi);
            node = (node << 1) + LOG_WAYS'(1) + LOG_WAYS'(go_hi);
        end
        return v;
    endfunction

    assign eligible       = ~lock_i & ~reserved_q;
    assign alloc_full_o   = ~|eligible;
    assign victim         = plru_victim(tree_q, eligible);
    assign alloc_gnt_o    = (state_q == GNT) && !flush_i;
    assign alloc_way_o    = way_q;
    assign alloc_way_oh_o = way_oh_q;
    assign reserved_o     = reserved_q;
    assign illegal_fill_o = illegal_q;

    always_comb begin
        state_d    = state_q;
        tree_d     = tree_q;
        reserved_d = reserved_q;
        way_d      = way_q;
        way_oh_d   = way_oh_q;
        illegal_d  = 1'b0;
        if (flush_i) begin
            state_d    = IDLE;
            tree_d     = '0;
            reserved_d = '0;
        end else begin
            // Tree updates chain touch -> fill -> grant so the later one wins per node.
            if (touch_valid_i) tree_d = plru_update(tree_d, touch_way_i);
            if (fill_done_i) begin
                if (reserved_q[fill_way_i]) begin
                    reserved_d[fill_way_i] = 1'b0;
                    tree_d                 = plru_update(tree_d, fill_way_i);
                end else begin
                    illegal_d = 1'b1;
                end
            end
            unique case (state_q)
                IDLE: if (alloc_req_i && !alloc_full_o) state_d = SEL;
                SEL: begin
                    // Eligibility may vanish via lock_i during SEL; back off rather than grant a bad way.
                    if (!alloc_req_i || alloc_full_o) begin
                        state_d = IDLE;
                    end else begin
                        state_d  = GNT;
                        way_d    = victim;
                        way_oh_d = WAYS'(1) << victim;
                    end
                end
                GNT: begin
                    reserved_d[way_q] = 1'b1;
                    tree_d            = plru_update(tree_d, way_q);
                    state_d           = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            tree_q     <= '0;
            reserved_q <= '0;
            way_q      <= '0;
            way_oh_q   <= '0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tree_q     <= tree_d;
            reserved_q <= reserved_d;
            way_q      <= way_d;
            way_oh_q   <= way_oh_d;
            illegal_q  <= illegal_d;
        end
    end

endmodule

// File: tb/tb_plru_way_allocator.sv
// Directed bench for plru_way_allocator (WAYS=8) with hand-computed victim sequences.
module tb_plru_way_allocator;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic       touch_valid = 1'b0;
    logic [2:0] touch_way = '0;
    logic [7:0] lock = '0;
    logic       alloc_req = 1'b0;
    logic       alloc_gnt;
    logic [2:0] alloc_way;
    logic [7:0] alloc_way_oh;
    logic       alloc_full;
    logic       fill_done = 1'b0;
    logic [2:0] fill_way = '0;
    logic [7:0] reserved;
    logic       illegal_fill;

    int total = 0;
    int bad   = 0;

    plru_way_allocator #(.WAYS(8)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .touch_valid_i  (touch_valid),
        .touch_way_i    (touch_way),
        .lock_i         (lock),
        .alloc_req_i    (alloc_req),
        .alloc_gnt_o    (alloc_gnt),
        .alloc_way_o    (alloc_way),
        .alloc_way_oh_o (alloc_way_oh),
        .alloc_full_o   (alloc_full),
        .fill_done_i    (fill_done),
        .fill_way_i     (fill_way),
        .reserved_o     (reserved),
        .illegal_fill_o (illegal_fill)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rst_way", 32'(alloc_way), 32'h0);
        check_eq("rst_oh", 32'(alloc_way_oh), 32'h0);
        check_eq("rst_gnt", 32'(alloc_gnt), 32'h0);
        check_eq("rst_reserved", 32'(reserved), 32'h0);
        check_eq("rst_illegal", 32'(illegal_fill), 32'h0);
        check_eq("rst_full", 32'(alloc_full), 32'(&lock));
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Starts and ends at a negedge with the FSM idle; grant must arrive 2 cycles after req.
    task automatic do_alloc(input logic [2:0] exp_way);
        int lat;
        bit seen;
        lat  = 0;
        seen = 1'b0;
        alloc_req = 1'b1;
        while (!seen && lat < 10) begin
            @(negedge clk);
            lat++;
            if (alloc_gnt) seen = 1'b1;
        end
        check_eq("gnt_seen", 32'(seen), 32'h1);
        check_eq("gnt_latency", 32'(lat), 32'd2);
        check_eq("alloc_way", 32'(alloc_way), 32'(exp_way));
        check_eq("alloc_oh", 32'(alloc_way_oh), 32'h1 << exp_way);
        alloc_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_full(input int cycles);
        alloc_req = 1'b1;
        repeat (cycles) begin
            @(negedge clk);
            check_eq("full_flag", 32'(alloc_full), 32'h1);
            check_eq("full_no_gnt", 32'(alloc_gnt), 32'h0);
        end
        alloc_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_fill(input logic [2:0] w);
        fill_done = 1'b1;
        fill_way  = w;
        @(negedge clk);
        fill_done = 1'b0;
    endtask

    task automatic do_touch(input logic [2:0] w);
        touch_valid = 1'b1;
        touch_way   = w;
        @(negedge clk);
        touch_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] seq [8];
        seq = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

        // First grant from reset, then fill the set in PLRU order.
        do_reset();
        do_alloc(seq[0]);
        check_eq("t1_reserved", 32'(reserved), 32'h01);
        for (int i = 1; i < 8; i++) do_alloc(seq[i]);
        check_eq("t2_reserved", 32'(reserved), 32'hFF);
        expect_full(4);

        // Refill completion frees way 5; it is the only candidate.
        do_fill(3'd5);
        check_eq("t5_reserved", 32'(reserved), 32'hDF);
        check_eq("t5_full", 32'(alloc_full), 32'h0);
        do_alloc(3'd5);
        check_eq("t5_reserved2", 32'(reserved), 32'hFF);
        fill_done = 1'b1;
        fill_way  = 3'd5;
        @(negedge clk);
        check_eq("t5_fill_ok_illegal", 32'(illegal_fill), 32'h0);
        check_eq("t5_fill_ok_res", 32'(reserved), 32'hDF);
        @(negedge clk);
        fill_done = 1'b0;
        check_eq("t5_illegal_pulse", 32'(illegal_fill), 32'h1);
        check_eq("t5_res_unchanged", 32'(reserved), 32'hDF);
        @(negedge clk);
        check_eq("t5_illegal_clear", 32'(illegal_fill), 32'h0);

        // Touches steer the victim away.
        do_reset();
        do_touch(3'd0);
        do_alloc(3'd4);
        do_touch(3'd4);
        do_alloc(3'd2);
        check_eq("t3_reserved", 32'(reserved), 32'h14);

        // Locks exclude ways; full until the only unlocked way is refilled.
        do_reset();
        lock = 8'hFE;
        do_alloc(3'd0);
        expect_full(3);
        do_fill(3'd0);
        check_eq("t4_reserved", 32'(reserved), 32'h00);
        do_alloc(3'd0);
        lock = 8'h00;
        @(negedge clk);

        // Flush in SEL aborts the grant and clears state.
        do_reset();
        do_alloc(3'd0);
        alloc_req = 1'b1;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_eq("t6_flush_no_gnt", 32'(alloc_gnt), 32'h0);
        check_eq("t6_flush_res", 32'(reserved), 32'h00);
        do_alloc(3'd0);
        alloc_req = 1'b1;
        @(negedge clk);
        alloc_req = 1'b0;
        @(negedge clk);
        check_eq("t6_drop_no_gnt", 32'(alloc_gnt), 32'h0);
        @(negedge clk);
        check_eq("t6_drop_no_gnt2", 32'(alloc_gnt), 32'h0);
        check_eq("t6_drop_res", 32'(reserved), 32'h01);
        check_eq("t6_way_hold", 32'(alloc_way), 32'h0);
        do_alloc(3'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
